// File: rtl/elastic_pipe_reg.sv
// Elastic pipeline of DEPTH valid/data stages with valid/ready handshake, bubble collapsing,
// synchronous flush and a combinational occupancy count.
module elastic_pipe_reg #(
  parameter int unsigned      WIDTH     = 8,
  parameter int unsigned      DEPTH     = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter int unsigned      CW        = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic [CW-1:0]    occupancy
);

  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] valid_d;
  logic [DEPTH-1:0] en;
  logic [DEPTH-1:0] src_valid;
  logic [DEPTH-1:0] load;
  logic [WIDTH-1:0] data_q   [DEPTH];
  logic [WIDTH-1:0] src_data [DEPTH];
  logic             all_full;

  // A stage may advance unless it and every stage ahead of it are full and the sink stalls.
  always_comb begin
    all_full = 1'b1;
    en       = '0;
    for (int k = int'(DEPTH) - 1; k >= 0; k--) begin
      all_full = all_full & valid_q[k];
      en[k]    = out_ready | ~all_full;
    end
  end

  for (genvar k = 0; k < DEPTH; k++) begin : g_src
    if (k == 0) begin : g_first
      assign src_valid[k] = in_valid;
      assign src_data[k]  = in_data;
    end else begin : g_rest
      assign src_valid[k] = valid_q[k-1];
      assign src_data[k]  = data_q[k-1];
    end
  end

  always_comb begin
    valid_d = flush ? '0 : ((en & src_valid) | (~en & valid_q));
    // Data only follows a valid source so an empty stage keeps its last word.
    load    = en & src_valid & {DEPTH{~flush}};
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= '0;
      for (int unsigned k = 0; k < DEPTH; k++) begin
        data_q[k] <= RESET_VAL;
      end
    end else begin
      valid_q <= valid_d;
      for (int unsigned k = 0; k < DEPTH; k++) begin
        if (load[k]) begin
          data_q[k] <= src_data[k];
        end
      end
    end
  end

  always_comb begin
    occupancy = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      occupancy = occupancy + CW'(valid_q[k]);
    end
  end

  assign in_ready  = en[0] & ~flush & reset_n;
  assign out_valid = valid_q[DEPTH-1] & ~flush;
  assign out_data  = data_q[DEPTH-1];

endmodule

// File: doc/elastic_pipe_reg.md
Name: elastic_pipe_reg

Overview:
- Parametrised successor to the team's single-bit registered pass-through.
- WIDTH-bit data path of DEPTH register stages, each carrying a valid bit.
- Valid/ready handshake on both sides, bubble collapsing, synchronous flush and an occupancy count.
- Used wherever a configurable retiming or pipeline delay with backpressure is needed between blocks.

Parameters:
- WIDTH, 8: data width in bits, legal range 1 to 64.
- DEPTH, 2: number of pipeline stages and maximum occupancy, legal range 1 to 8.
- RESET_VAL, 0: value loaded into every data stage on reset, WIDTH bits.
- CW, $clog2(DEPTH+1): width of occupancy output. Derived; not overridden.

Ports:
- clock  input  1  rising-edge clock.
- reset_n  input  1  asynchronous active-low reset.
- flush  input  1  synchronous clear of all valid bits.
- in_valid  input  1  upstream data valid.
- in_data  input  WIDTH  upstream data.
- in_ready  output  1  block accepts in_data this cycle.
- out_valid  output  1  out_data valid.
- out_data  output  WIDTH  data from last stage.
- out_ready  input  1  downstream accepts this cycle.
- occupancy  output  CW  number of valid stages, 0 to DEPTH.

Behaviour:
- Reset and clocking: reset reset_n, asynchronous, active-low; clock clock.
- Stages and outputs:
  - Stages are numbered 0 (input side) to DEPTH-1 (output side); each holds v[k] and d[k].
  - On reset assertion, immediately: all v[k]=0 and all d[k]=RESET_VAL, so out_valid=0, out_data=RESET_VAL, occupancy=0.
  - in_ready is gated to 0 while reset_n=0 and rises combinationally once reset deasserts.
- Advance enables (combinational, backward chain):
  - en[DEPTH-1] = out_ready | ~v[DEPTH-1].
  - en[k] = en[k+1] | ~v[k].
  - in_ready = en[0] & ~flush & reset_n.
  - A stage with an empty stage ahead of it advances regardless of out_ready (bubble collapsing).
- Clock edge, flush=0:
  - Stage 0: when en[0], v[0] <= in_valid.
  - Stage k>0: when en[k], v[k] <= v[k-1].
  - Data: d[k] loads from its source (in_data for k=0, d[k-1] otherwise) only when en[k] and the source valid bit is 1; otherwise d[k] holds.
- Transfers:
  - Input transfer = in_valid & in_ready.
  - Output transfer = out_valid & out_ready.
  - Both may occur in the same cycle; the full pipe then streams at one word per cycle.
- Latency:
  - Unstalled, a word accepted on edge N appears on out_data after edge N+DEPTH-1 (visible in cycle N+DEPTH-1).
  - The first stage register counts as one cycle, so DEPTH=1 gives out_valid the cycle after acceptance.
- Full pipe (all v=1), out_ready=0:
  - in_ready=0; all stages hold.
  - in_valid/in_data are ignored, and upstream must hold them.
- Empty pipe: out_valid=0; out_data holds the last delivered word (or RESET_VAL), since data does not load from invalid sources.
- Flush=1 (synchronous, overrides all):
  - out_valid forced 0 combinationally during the flush cycle, so no output transfer occurs.
  - in_ready=0, so no input transfer occurs.
  - On the edge all v[k] <= 0 and d[k] holds.
  - occupancy reads 0 on the following cycle.
- occupancy = popcount of v[], combinational from registers; it reflects the pre-flush count during the flush cycle.
- Protocol:
  - out_valid never deasserts without an output transfer, except on flush or reset.
  - out_data is stable while out_valid=1 & out_ready=0.
- Reset mid-operation: all in-flight words are discarded immediately; there is no partial-transfer state.

Test Plan:
- Streaming. WIDTH=8, DEPTH=3, out_ready=1; drive 0x11, 0x22, 0x33, 0x44 on consecutive cycles. Required response:
  - out_data shows 0x11 to 0x44 on consecutive cycles, 0x11 two cycles after acceptance.
  - occupancy settles at 3; in_ready stays 1 throughout.
- Backpressure fill. out_ready=0; drive 0xA0 to 0xA4. Required response:
  - 0xA0 to 0xA2 are accepted, then in_ready=0 and occupancy=3.
  - out_data=0xA0 holds stable; after out_ready=1 the output sequence is 0xA0, 0xA1, 0xA2, 0xA3, 0xA4 with no loss or duplication.
- Bubble collapse. One word 0x5A is accepted, idle cycles follow, out_ready=0; then 0x5B arrives. Required response:
  - 0x5A reaches stage 2 regardless of out_ready.
  - 0x5B advances to stage 1; occupancy=2.
- Simultaneous transfer when full. Pipe full with 0x01 to 0x03; in_valid=1 with 0x04 and out_ready=1 in the same cycle. Required response:
  - 0x01 leaves and 0x04 enters in that cycle; occupancy stays 3.
- Flush. occupancy=2 with in_valid=1 (0x77); pulse flush for one cycle. Required response:
  - in_ready=0 and out_valid=0 during the flush cycle; 0x77 is not accepted.
  - Next cycle occupancy=0 and out_valid=0.
- Async reset. Pipe full; assert reset_n=0 mid-cycle. Required response:
  - out_valid=0, out_data=RESET_VAL (override 0xC3), occupancy=0 and in_ready=0 immediately, without waiting for a clock edge.
  - in_ready=1 after release.
